rom_dl_sequencer: RTL and testbench

- Sits between the `data_io` download stream and SDRAM port 1.
- Packs byte-wide ROM download writes into 16-bit words and buffers them in a small FIFO.
- Issues each word to the SDRAM controller over the toggle req/ack handshake.
- Parks the CPU ROM fetch address while downloading and sequences core reset/`rom_loaded` so the game core starts only after the last word is committed.

---
 rtl/rom_dl_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_rom_dl_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_dl_sequencer.sv
// ROM download sequencer: packs data_io bytes into 16-bit words, queues them,
// writes them to SDRAM port 1 over a toggle handshake and sequences core reset.
module rom_dl_sequencer #(
    parameter int          ROM_INDEX  = 0,
    parameter int          FIFO_DEPTH = 4,
    parameter int          RESET_HOLD = 16,
    parameter logic [16:0] PARK_ADDR  = 17'h1ffff
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        user_reset,
    input  logic [16:0] cpu_addr,
    output logic [16:0] sdram_cpu_addr,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port1_we,
    output logic        busy,
    output logic        rom_loaded,
    output logic        core_reset,
    output logic        overflow,
    output logic [23:0] words_written
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int HOLD_W = (RESET_HOLD > 0) ? $clog2(RESET_HOLD + 1) : 1;
    localparam int ENT_W  = 41;  // {a[22:0], ds[1:0], d[15:0]}

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic unused_addr_msb;
    assign unused_addr_msb = ioctl_addr[24];

    logic              accept;
    logic [22:0]       byte_waddr;
    logic              dl_fall;
    logic              dl_prev_reg;

    logic              pend_valid_reg, pend_valid_next;
    logic [22:0]       pend_addr_reg, pend_addr_next;
    logic [7:0]        pend_data_reg, pend_data_next;
    logic              defer_valid_reg, defer_valid_next;
    logic [ENT_W-1:0]  defer_entry_reg, defer_entry_next;
    logic              push;
    logic [ENT_W-1:0]  push_entry;
    logic [ENT_W-1:0]  pend_entry;
    logic [ENT_W-1:0]  odd_entry;

    assign accept     = ioctl_wr & ioctl_download & (ioctl_index == 8'(ROM_INDEX));
    assign byte_waddr = ioctl_addr[23:1];
    assign dl_fall    = dl_prev_reg & ~ioctl_download;
    assign pend_entry = {pend_addr_reg, 2'b01, 8'h00, pend_data_reg};
    assign odd_entry  = {byte_waddr, 2'b10, ioctl_dout, 8'h00};

    // A deferred odd byte is only ever created while flushing a mismatched
    // pending byte, so pending and deferred are never valid together.
    always_comb begin
        push             = 1'b0;
        push_entry       = defer_entry_reg;
        pend_valid_next  = pend_valid_reg;
        pend_addr_next   = pend_addr_reg;
        pend_data_next   = pend_data_reg;
        defer_valid_next = 1'b0;
        defer_entry_next = defer_entry_reg;
        if (defer_valid_reg) begin
            push = 1'b1;
        end
        if (accept) begin
            if (!ioctl_addr[0]) begin
                if (pend_valid_reg) begin
                    push       = 1'b1;
                    push_entry = pend_entry;
                end
                pend_valid_next = 1'b1;
                pend_addr_next  = byte_waddr;
                pend_data_next  = ioctl_dout;
            end else if (pend_valid_reg && (pend_addr_reg == byte_waddr)) begin
                push            = 1'b1;
                push_entry      = {byte_waddr, 2'b11, ioctl_dout, pend_data_reg};
                pend_valid_next = 1'b0;
            end else if (pend_valid_reg || defer_valid_reg) begin
                if (pend_valid_reg) begin
                    push       = 1'b1;
                    push_entry = pend_entry;
                end
                pend_valid_next  = 1'b0;
                defer_valid_next = 1'b1;
                defer_entry_next = odd_entry;
            end else begin
                push       = 1'b1;
                push_entry = odd_entry;
            end
        end else if (dl_fall && pend_valid_reg) begin
            push            = 1'b1;
            push_entry      = pend_entry;
            pend_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_prev_reg     <= 1'b0;
            pend_valid_reg  <= 1'b0;
            pend_addr_reg   <= '0;
            pend_data_reg   <= '0;
            defer_valid_reg <= 1'b0;
            defer_entry_reg <= '0;
        end else begin
            dl_prev_reg     <= ioctl_download;
            pend_valid_reg  <= pend_valid_next;
            pend_addr_reg   <= pend_addr_next;
            pend_data_reg   <= pend_data_next;
            defer_valid_reg <= defer_valid_next;
            defer_entry_reg <= defer_entry_next;
        end
    end

    // Word FIFO; storage is left unreset so it maps onto plain RAM.
    logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             fifo_empty, fifo_full, pop, push_ok;
    logic [ENT_W-1:0] head_entry;
    logic [0:0]       state_reg;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == (PTR_W + 1)'(FIFO_DEPTH));
    assign pop        = (state_reg == ST_IDLE) & ~fifo_empty;
    assign push_ok    = push & (~fifo_full | pop);
    assign head_entry = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (push_ok && !pop)      count_reg <= count_reg + (PTR_W + 1)'(1);
            else if (!push_ok && pop) count_reg <= count_reg - (PTR_W + 1)'(1);
            if (push && !push_ok)     overflow  <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            port1_req     <= 1'b0;
            port1_a       <= '0;
            port1_ds      <= '0;
            port1_d       <= '0;
            words_written <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        {port1_a, port1_ds, port1_d} <= head_entry;
                        port1_req <= ~port1_req;
                        state_reg <= ST_WAIT;
                    end
                end
                default: begin
                    if (port1_ack == port1_req) begin
                        words_written <= words_written + 24'd1;
                        state_reg     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign port1_we       = 1'b1;
    assign busy           = ioctl_download | ~fifo_empty | (state_reg != ST_IDLE)
                          | pend_valid_reg | defer_valid_reg;
    assign sdram_cpu_addr = busy ? PARK_ADDR : cpu_addr;

    // Load sequencing: core_reset is computed from next-state values so it
    // releases exactly RESET_HOLD+1 cycles after busy falls.
    logic              busy_prev_reg, busy_fall, any_byte_reg, rom_loaded_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;

    assign busy_fall       = busy_prev_reg & ~busy;
    assign rom_loaded_next = rom_loaded | (busy_fall & any_byte_reg);

    always_comb begin
        hold_next = hold_reg;
        if (busy_fall)            hold_next = HOLD_W'(RESET_HOLD);
        else if (hold_reg != '0)  hold_next = hold_reg - HOLD_W'(1);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            busy_prev_reg <= 1'b0;
            any_byte_reg  <= 1'b0;
            rom_loaded    <= 1'b0;
            hold_reg      <= '0;
            core_reset    <= 1'b1;
        end else begin
            busy_prev_reg <= busy;
            if (accept)         any_byte_reg <= 1'b1;
            else if (busy_fall) any_byte_reg <= 1'b0;
            rom_loaded    <= rom_loaded_next;
            hold_reg      <= hold_next;
            core_reset    <= user_reset | ~rom_loaded_next | busy | (hold_next != '0);
        end
    end

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Directed bench for rom_dl_sequencer: packing, handshake, overflow and
// reset/load sequencing, with an SDRAM ack model and a write log.
module tb_rom_dl_sequencer;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        user_reset = 1'b0;
    logic [16:0] cpu_addr;
    logic [16:0] sdram_cpu_addr;
    logic        port1_req;
    logic        port1_ack;
    logic [22:0] port1_a;
    logic [1:0]  port1_ds;
    logic [15:0] port1_d;
    logic        port1_we;
    logic        busy;
    logic        rom_loaded;
    logic        core_reset;
    logic        overflow;
    logic [23:0] words_written;

    logic        ack_hold = 1'b0;
    logic        req_seen = 1'b0;
    logic [40:0] wr_q [$];
    int          vectors = 0;
    int          miscompares = 0;
    int          n;

    rom_dl_sequencer dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .user_reset     (user_reset),
        .cpu_addr       (cpu_addr),
        .sdram_cpu_addr (sdram_cpu_addr),
        .port1_req      (port1_req),
        .port1_ack      (port1_ack),
        .port1_a        (port1_a),
        .port1_ds       (port1_ds),
        .port1_d        (port1_d),
        .port1_we       (port1_we),
        .busy           (busy),
        .rom_loaded     (rom_loaded),
        .core_reset     (core_reset),
        .overflow       (overflow),
        .words_written  (words_written)
    );

    always #5 clk_sys = ~clk_sys;

    // SDRAM model: acknowledges one cycle after a request toggle unless frozen.
    always @(posedge clk_sys or posedge reset) begin
        if (reset)          port1_ack <= 1'b0;
        else if (!ack_hold) port1_ack <= port1_req;
    end

    // Log every issued write.
    always @(negedge clk_sys) begin
        if (reset) begin
            req_seen = 1'b0;
        end else if (port1_req !== req_seen) begin
            wr_q.push_back({port1_a, port1_ds, port1_d});
            req_seen = port1_req;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [40:0] mk(input logic [22:0] a, input logic [1:0] ds,
                                       input logic [15:0] d);
        return {a, ds, d};
    endfunction

    function automatic logic [40:0] wr_at(input int i);
        if (i < wr_q.size()) return wr_q[i];
        return 41'bx;
    endfunction

    task automatic tick(input int cycles);
        repeat (cycles) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(posedge clk_sys);
        #1;
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300 && busy; i++) begin
            @(posedge clk_sys);
            #1;
        end
        check(tag, busy, 1'b0);
    endtask

    initial begin
        ioctl_index = 8'd0;
        ioctl_addr  = '0;
        ioctl_dout  = '0;
        cpu_addr    = 17'h00abc;
        tick(3);

        // Reset state
        check("rst_req", port1_req, 1'b0);
        check("rst_a", port1_a, 23'd0);
        check("rst_ds", port1_ds, 2'd0);
        check("rst_d", port1_d, 16'd0);
        check("rst_we", port1_we, 1'b1);
        check("rst_loaded", rom_loaded, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_words", words_written, 24'd0);
        check("rst_core_reset", core_reset, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_cpu_addr", sdram_cpu_addr, 17'h00abc);
        reset = 1'b0;
        tick(2);

        // Wrong index: strobes ignored
        ioctl_index    = 8'd1;
        ioctl_download = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(25'(i), 8'(8'h90 + i));
        check("wi_park", sdram_cpu_addr, 17'h1ffff);
        ioctl_download = 1'b0;
        tick(25);
        check("wi_req", port1_req, 1'b0);
        check("wi_nwr", wr_q.size(), 0);
        check("wi_loaded", rom_loaded, 1'b0);
        check("wi_core_reset", core_reset, 1'b1);
        ioctl_index = 8'd0;

        // Contiguous 4-byte download with first-word latency
        ioctl_download = 1'b1;
        send_byte(25'd0, 8'h12);
        send_byte(25'd1, 8'h34);
        check("lat_n1_req", port1_req, 1'b0);
        tick(1);
        check("lat_n2_req", port1_req, 1'b1);
        check("lat_n2_word", {port1_a, port1_ds, port1_d}, mk(23'd0, 2'b11, 16'h3412));
        tick(3);
        send_byte(25'd2, 8'h56);
        send_byte(25'd3, 8'h78);
        ioctl_download = 1'b0;
        wait_idle("t2_idle");
        n = 0;
        while (core_reset && n < 40) begin
            tick(1);
            n++;
        end
        check("t2_core_reset_hold", n, 17);
        check("t2_wr0", wr_at(0), mk(23'd0, 2'b11, 16'h3412));
        check("t2_wr1", wr_at(1), mk(23'd1, 2'b11, 16'h7856));
        check("t2_words", words_written, 24'd2);
        check("t2_loaded", rom_loaded, 1'b1);
        check("t2_cpu_addr", sdram_cpu_addr, 17'h00abc);

        user_reset = 1'b1;
        tick(1);
        check("ur_core_reset_on", core_reset, 1'b1);
        user_reset = 1'b0;
        tick(1);
        check("ur_core_reset_off", core_reset, 1'b0);

        // Odd-length download
        ioctl_download = 1'b1;
        tick(1);
        check("t3_core_reset", core_reset, 1'b1);
        check("t3_loaded_sticky", rom_loaded, 1'b1);
        send_byte(25'd0, 8'hAA);
        send_byte(25'd1, 8'hBB);
        tick(2);
        send_byte(25'd2, 8'hCC);
        tick(2);
        ioctl_download = 1'b0;
        wait_idle("t3_idle");
        check("t3_wr2", wr_at(2), mk(23'd0, 2'b11, 16'hBBAA));
        check("t3_wr3", wr_at(3), mk(23'd1, 2'b01, 16'h00CC));
        check("t3_words", words_written, 24'd4);

        // Non-contiguous bytes
        ioctl_download = 1'b1;
        send_byte(25'd4, 8'h11);
        tick(3);
        send_byte(25'd9, 8'h22);
        tick(2);
        ioctl_download = 1'b0;
        wait_idle("t4_idle");
        check("t4_wr4", wr_at(4), mk(23'd2, 2'b01, 16'h0011));
        check("t4_wr5", wr_at(5), mk(23'd4, 2'b10, 16'h2200));
        check("t4_words", words_written, 24'd6);
        check("t4_nwr", wr_q.size(), 6);

        // Overflow with ack frozen
        ack_hold       = 1'b1;
        ioctl_download = 1'b1;
        for (int i = 0; i < 10; i++) send_byte(25'(i), 8'(8'hA0 + i));
        check("t5_ovf_before", overflow, 1'b0);
        for (int i = 10; i < 12; i++) send_byte(25'(i), 8'(8'hA0 + i));
        check("t5_ovf_after", overflow, 1'b1);
        check("t5_nwr_held", wr_q.size(), 7);
        ioctl_download = 1'b0;
        ack_hold       = 1'b0;
        wait_idle("t5_idle");
        check("t5_wr6", wr_at(6), mk(23'd0, 2'b11, 16'hA1A0));
        check("t5_wr7", wr_at(7), mk(23'd1, 2'b11, 16'hA3A2));
        check("t5_wr8", wr_at(8), mk(23'd2, 2'b11, 16'hA5A4));
        check("t5_wr9", wr_at(9), mk(23'd3, 2'b11, 16'hA7A6));
        check("t5_wr10", wr_at(10), mk(23'd4, 2'b11, 16'hA9A8));
        check("t5_nwr", wr_q.size(), 11);
        check("t5_words", words_written, 24'd11);
        check("t5_ovf_sticky", overflow, 1'b1);

        // Reset while a write is in flight
        ioctl_download = 1'b1;
        send_byte(25'd0, 8'h01);
        send_byte(25'd1, 8'h02);
        tick(4);
        check("t6_words", words_written, 24'd12);
        ack_hold = 1'b1;
        send_byte(25'd2, 8'h03);
        send_byte(25'd3, 8'h04);
        tick(1);
        check("t6_req_wait", port1_req, 1'b1);
        check("t6_park", sdram_cpu_addr, 17'h1ffff);
        reset          = 1'b1;
        ioctl_download = 1'b0;
        tick(1);
        check("t6_req", port1_req, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_core_reset", core_reset, 1'b1);
        check("t6_words_clr", words_written, 24'd0);
        check("t6_loaded_clr", rom_loaded, 1'b0);
        check("t6_ovf_clr", overflow, 1'b0);
        check("t6_a_clr", port1_a, 23'd0);
        reset    = 1'b0;
        ack_hold = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
